// File: rtl/pdm_pkg.sv
// Shared types and constants for the PCM-to-PDM transmitter.
package pdm_pkg;

    localparam int PDM_SAMPLE_BITS = 8;

    function automatic int pdm_offset(input int bits);
        return 1 << (bits - 1);
    endfunction

    localparam int PDM_OFFSET = pdm_offset(PDM_SAMPLE_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pdm_state_t;

    // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous show-ahead sample FIFO with level output and a registered ready flag.
module pdm_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LVL_W-1:0] level_next;

    assign empty   = (level == '0);
    assign do_push = push && (level != LVL_FULL);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_next = level - LVL_W'(1);
        end
    end

    // Ready follows the registered level, so a pop on a full FIFO does not
    // open the door until the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            ready <= (level_next != LVL_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pdm_modulator.sv
// PCM-to-PDM transmitter: sample FIFO, bit-tick divider, run FSM and first-order
// sigma-delta modulator. Build option PDM_DITHER_EN adds an LFSR carry-in dither.
//
// state | meaning
// IDLE  | counters, accumulator and pdm_out held at 0, no strobes
// RUN   | divider ticks every OSR_DIV cycles, one PDM bit per tick
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int SAMPLE_BITS = PDM_SAMPLE_BITS,
    parameter int OSR         = 16,
    parameter int OSR_DIV     = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [SAMPLE_BITS-1:0]        sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pdm_out,
    output logic                          pdm_strobe,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV_W = $clog2(OSR_DIV);
    localparam int BIT_W = $clog2(OSR);
    localparam int ACC_W = SAMPLE_BITS + 1;
    localparam logic [SAMPLE_BITS-1:0] OFFSET   = SAMPLE_BITS'(pdm_offset(SAMPLE_BITS));
    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(OSR_DIV - 1);

    pdm_state_t             state;
    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [SAMPLE_BITS-1:0] acc;
    logic [SAMPLE_BITS-1:0] cur_sample;

    logic                   tick;
    logic                   boundary;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [SAMPLE_BITS-1:0] fifo_head;
    logic [SAMPLE_BITS-1:0] tick_sample;
    logic [SAMPLE_BITS-1:0] u;
    logic [ACC_W-1:0]       acc_next;
    logic                   carry_in;

    pdm_sample_fifo #(
        .WIDTH (SAMPLE_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sample_valid & sample_ready),
        .push_data (sample_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .ready     (sample_ready),
        .level     (fifo_level)
    );

    assign tick     = (state == RUN) && enable && (div_cnt == DIV_LAST);
    assign boundary = tick && (bit_cnt == '0);
    assign fifo_pop = boundary && !fifo_empty;

    // The popped head drives this same tick's bit; an empty FIFO plays silence.
    assign tick_sample = boundary ? (fifo_empty ? '0 : fifo_head) : cur_sample;
    assign u           = tick_sample + OFFSET;
    assign acc_next    = {1'b0, acc} + {1'b0, u} + ACC_W'(carry_in);

`ifdef PDM_DITHER_EN
    logic [7:0] lfsr;

    assign carry_in = lfsr[0];

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || !enable) begin
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            lfsr <= lfsr_step(lfsr);
        end
    end
`else
    assign carry_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            cur_sample <= '0;
            pdm_out    <= 1'b0;
            pdm_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            pdm_strobe <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    acc        <= '0;
                    cur_sample <= '0;
                    pdm_out    <= 1'b0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        // Abort: the in-flight sample is dropped, queued samples stay.
                        state      <= IDLE;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        acc        <= '0;
                        cur_sample <= '0;
                        pdm_out    <= 1'b0;
                    end else if (tick) begin
                        div_cnt    <= '0;
                        bit_cnt    <= bit_cnt + BIT_W'(1);
                        acc        <= acc_next[SAMPLE_BITS-1:0];
                        pdm_out    <= acc_next[SAMPLE_BITS];
                        pdm_strobe <= 1'b1;
                        underrun   <= boundary && fifo_empty;
                        if (boundary) begin
                            cur_sample <= tick_sample;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: per-window bit patterns from a vector table
// plus hand-written reset, backpressure, underrun and abort sequences.
module tb_pdm_modulator;
    localparam int OSR     = 16;
    localparam int OSR_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       pdm_out;
    logic       pdm_strobe;
    logic       underrun;
    logic [2:0] fifo_level;

    always #5 clk = ~clk;

    pdm_modulator #(
        .SAMPLE_BITS (8),
        .OSR         (OSR),
        .OSR_DIV     (OSR_DIV),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pdm_out      (pdm_out),
        .pdm_strobe   (pdm_strobe),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    typedef struct {
        logic [7:0]  sample;
        logic        has_sample;
        logic [15:0] exp_bits;
        logic        exp_ur;
    } win_t;

    win_t       tbl[8];
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         n_acc    = 0;
    int         stray_ur = 0;
    logic [7:0] push_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: feed queued samples, advance to #1 after the edge, retire handshakes.
    task automatic step();
        logic hs;
        if (!sample_valid && push_q.size() > 0) begin
            sample_in    = push_q.pop_front();
            sample_valid = 1'b1;
        end
        hs = sample_valid && sample_ready;
        @(posedge clk);
        #1;
        if (hs === 1'b1) begin
            sample_valid = 1'b0;
            n_acc++;
        end
        if (underrun === 1'b1 && pdm_strobe !== 1'b1) stray_ur++;
    endtask

    task automatic wait_strobe(output logic b, output logic ur, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (pdm_strobe !== 1'b1 && cyc < 40);
        if (pdm_strobe !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL strobe_timeout: none within %0d cycles, expected one", cyc);
        end
        b  = pdm_out;
        ur = underrun;
    endtask

    task automatic collect(input int nbits, input int first_gap, output logic [15:0] bits,
                           output logic ur0, output int ur_rest, output int bad_gap);
        logic b;
        logic ur;
        int   cyc;
        bits    = '0;
        ur0     = 1'b0;
        ur_rest = 0;
        bad_gap = 0;
        for (int i = 0; i < nbits; i++) begin
            wait_strobe(b, ur, cyc);
            bits[i] = b;
            if (cyc != ((i == 0) ? first_gap : OSR_DIV)) bad_gap++;
            if (i == 0) ur0 = ur;
            else if (ur === 1'b1) ur_rest++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] bits;
        logic [15:0] hi;
        logic        ur0;
        logic        ur0_hi;
        int          ur_rest;
        int          bad_gap;
        int          ur_rest2;
        int          bad_gap2;
        int          ns;

        // Windows run back to back; the accumulator carries over between them.
        tbl[0] = '{8'h00, 1'b1, 16'hAAAA, 1'b0};
        tbl[1] = '{8'h80, 1'b1, 16'h0000, 1'b0};
        tbl[2] = '{8'h7F, 1'b1, 16'hFFFE, 1'b0};
        tbl[3] = '{8'h40, 1'b1, 16'h7777, 1'b0};
        tbl[4] = '{8'hC0, 1'b1, 16'h1111, 1'b0};
        tbl[5] = '{8'h00, 1'b0, 16'h5555, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 16'h5555, 1'b1};
        tbl[7] = '{8'h7F, 1'b1, 16'hFFFF, 1'b0};

        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 8'h11;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_pdm_out", 32'(pdm_out), 32'd0);
            check("rst_strobe", 32'(pdm_strobe), 32'd0);
            check("rst_underrun", 32'(underrun), 32'd0);
            check("rst_level", 32'(fifo_level), 32'd0);
            check("rst_ready", 32'(sample_ready), 32'd0);
        end
        rst          = 1'b0;
        sample_valid = 1'b0;
        step();
        check("post_rst_ready", 32'(sample_ready), 32'd1);
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_accepted", 32'(n_acc), 32'd0);

        // Backpressure with the modulator idle.
        for (int i = 0; i < 5; i++) push_q.push_back(tbl[i].sample);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_level", 32'(fifo_level), 32'(i + 1));
        end
        check("bp_ready_full", 32'(sample_ready), 32'd0);
        step();
        step();
        check("bp_level_held", 32'(fifo_level), 32'd4);
        check("bp_accepted", 32'(n_acc), 32'd4);
        check("bp_valid_pending", 32'(sample_valid), 32'd1);

        enable = 1'b1;
        for (int w = 0; w < 8; w++) begin
            if (w == 6) begin
                collect(8, OSR_DIV, bits, ur0, ur_rest, bad_gap);
                push_q.push_back(8'h7F);
                push_q.push_back(8'h7F);
                push_q.push_back(8'h00);
                push_q.push_back(8'h80);
                collect(8, OSR_DIV, hi, ur0_hi, ur_rest2, bad_gap2);
                bits    = {hi[7:0], bits[7:0]};
                ur_rest = ur_rest + ur_rest2 + ((ur0_hi === 1'b1) ? 1 : 0);
                bad_gap = bad_gap + bad_gap2;
            end else begin
                collect(16, (w == 0) ? OSR_DIV + 1 : OSR_DIV, bits, ur0, ur_rest, bad_gap);
            end
            check($sformatf("win%0d_bits", w), 32'(bits), 32'(tbl[w].exp_bits));
            check($sformatf("win%0d_underrun", w), 32'(ur0), 32'(tbl[w].exp_ur));
            check($sformatf("win%0d_extra_ur", w), 32'(ur_rest), 32'd0);
            check($sformatf("win%0d_tick_spacing", w), 32'(bad_gap), 32'd0);
            if (w == 1) check("late_push_accepted", 32'(n_acc), 32'd5);
        end
        check("level_after_h", 32'(fifo_level), 32'd3);

        // Abort at bit 7 of a +127 window with two samples still queued.
        collect(8, OSR_DIV, bits, ur0, ur_rest, bad_gap);
        check("abort_win_bits", 32'(bits[7:0]), 32'hFF);
        check("abort_win_ur", 32'(ur0), 32'd0);
        enable = 1'b0;
        step();
        check("abort_pdm_out", 32'(pdm_out), 32'd0);
        ns = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (pdm_strobe === 1'b1) ns++;
        end
        check("abort_no_strobes", 32'(ns), 32'd0);
        check("abort_level", 32'(fifo_level), 32'd2);
        check("abort_pdm_idle", 32'(pdm_out), 32'd0);

        enable = 1'b1;
        collect(16, OSR_DIV + 1, bits, ur0, ur_rest, bad_gap);
        check("reen_bits", 32'(bits), 32'hAAAA);
        check("reen_ur", 32'(ur0), 32'd0);
        check("reen_spacing", 32'(bad_gap), 32'd0);
        collect(16, OSR_DIV, bits, ur0, ur_rest, bad_gap);
        check("reen2_bits", 32'(bits), 32'h0000);
        check("reen2_ur", 32'(ur0), 32'd0);
        collect(1, OSR_DIV, bits, ur0, ur_rest, bad_gap);
        check("final_underrun", 32'(ur0), 32'd1);
        check("final_bit", 32'(bits[0]), 32'd0);
        enable = 1'b0;
        step();
        step();
        check("end_pdm_out", 32'(pdm_out), 32'd0);
        check("end_level", 32'(fifo_level), 32'd0);
        check("end_accepted", 32'(n_acc), 32'd9);
        check("stray_underrun", 32'(stray_ur), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
